// File: rtl/iomem_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | iomem_scheduler: one-outstanding iomem sequencer with page decode,     |
// | per-access watchdog and a firmware-visible fault/status page.  Rev 1.0 |
// +------------------------------------------------------------------------+
module iomem_scheduler #(
   parameter int                NSLOT        = 5,
   parameter logic [7:0]        BASE_ID      = 8'h03,
   parameter logic [NSLOT-1:0]  PRESENT      = {NSLOT{1'b1}},
   parameter logic [7:0]        STATUS_ID    = 8'h08,
   parameter int                TIMEOUT      = 255,
   parameter logic [31:0]       TIMEOUT_DATA = 32'hDEAD_BEEF
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  m_valid,
   output logic                  m_ready,
   input  logic [3:0]            m_wstrb,
   input  logic [31:0]           m_addr,
   input  logic [31:0]           m_wdata,
   output logic [31:0]           m_rdata,
   output logic [NSLOT-1:0]      s_valid,
   output logic [3:0]            s_wstrb,
   output logic [31:0]           s_addr,
   output logic [31:0]           s_wdata,
   input  logic [NSLOT-1:0]      s_ready,
   input  logic [32*NSLOT-1:0]   s_rdata,
   output logic                  timeout_irq
);

   localparam int          c_IW      = (NSLOT > 1) ? $clog2(NSLOT) : 1;
   localparam logic [15:0] c_WD_LAST = 16'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   state_t            r_state,       w_state_nxt;
   logic [NSLOT-1:0]  r_s_valid,     w_s_valid_nxt;
   logic [3:0]        r_s_wstrb,     w_s_wstrb_nxt;
   logic [31:0]       r_s_addr,      w_s_addr_nxt;
   logic [31:0]       r_s_wdata,     w_s_wdata_nxt;
   logic [c_IW-1:0]   r_idx,         w_idx_nxt;
   logic [15:0]       r_wd,          w_wd_nxt;
   logic [31:0]       r_m_rdata,     w_m_rdata_nxt;
   logic              r_irq,         w_irq_nxt;
   logic [15:0]       r_fault_count, w_fault_count_nxt;
   logic [2:0]        r_last_slot,   w_last_slot_nxt;
   logic [31:0]       r_fault_addr,  w_fault_addr_nxt;

   logic              w_hit;
   logic [c_IW-1:0]   w_hit_idx;
   logic [31:0]       w_status_rd;
   logic [31:0]       w_sel_rdata;

   // Page decode: only populated slots are considered mapped.
   always_comb begin
      w_hit     = 1'b0;
      w_hit_idx = '0;
      for (int i = 0; i < NSLOT; i++) begin
         if (PRESENT[i] && (m_addr[31:24] == 8'(BASE_ID + 8'(i)))) begin
            w_hit     = 1'b1;
            w_hit_idx = c_IW'(i);
         end
      end
   end

   always_comb begin
      w_status_rd = '0;
      if (m_addr[23:0] == 24'h0)
         w_status_rd = {r_fault_count, 13'b0, r_last_slot};
      else if (m_addr[23:0] == 24'h4)
         w_status_rd = r_fault_addr;
   end

   assign w_sel_rdata = s_rdata[{r_idx, 5'b0} +: 32];

   always_comb begin
      w_state_nxt       = r_state;
      w_s_valid_nxt     = r_s_valid;
      w_s_wstrb_nxt     = r_s_wstrb;
      w_s_addr_nxt      = r_s_addr;
      w_s_wdata_nxt     = r_s_wdata;
      w_idx_nxt         = r_idx;
      w_wd_nxt          = r_wd;
      w_m_rdata_nxt     = r_m_rdata;
      w_irq_nxt         = 1'b0;
      w_fault_count_nxt = r_fault_count;
      w_last_slot_nxt   = r_last_slot;
      w_fault_addr_nxt  = r_fault_addr;
      case (r_state)
         ST_IDLE: begin
            if (m_valid) begin
               if (w_hit) begin
                  w_s_addr_nxt             = m_addr;
                  w_s_wdata_nxt            = m_wdata;
                  w_s_wstrb_nxt            = m_wstrb;
                  w_s_valid_nxt            = '0;
                  w_s_valid_nxt[w_hit_idx] = 1'b1;
                  w_idx_nxt                = w_hit_idx;
                  w_wd_nxt                 = '0;
                  w_state_nxt              = ST_ACCESS;
               end else if (m_addr[31:24] == STATUS_ID) begin
                  // Read returns the pre-clear value; the clear lands on the same edge.
                  w_m_rdata_nxt = w_status_rd;
                  if ((m_addr[23:0] == 24'h0) && (m_wstrb != 4'h0)) begin
                     w_fault_count_nxt = '0;
                     w_last_slot_nxt   = '0;
                  end
                  w_state_nxt = ST_RESP;
               end else begin
                  w_m_rdata_nxt = '0;
                  w_state_nxt   = ST_RESP;
               end
            end
         end
         ST_ACCESS: begin
            w_wd_nxt = r_wd + 16'd1;
            if (s_ready[r_idx]) begin
               w_m_rdata_nxt = w_sel_rdata;
               w_s_valid_nxt = '0;
               w_state_nxt   = ST_RESP;
            end else if (r_wd == c_WD_LAST) begin
               w_m_rdata_nxt     = TIMEOUT_DATA;
               w_s_valid_nxt     = '0;
               w_fault_count_nxt = (r_fault_count == 16'hFFFF) ? r_fault_count
                                                                : r_fault_count + 16'd1;
               w_last_slot_nxt   = 3'(r_idx);
               w_fault_addr_nxt  = r_s_addr;
               w_irq_nxt         = 1'b1;
               w_state_nxt       = ST_RESP;
            end
         end
         ST_RESP: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state       <= ST_IDLE;
         r_s_valid     <= '0;
         r_s_wstrb     <= '0;
         r_s_addr      <= '0;
         r_s_wdata     <= '0;
         r_idx         <= '0;
         r_wd          <= '0;
         r_m_rdata     <= '0;
         r_irq         <= 1'b0;
         r_fault_count <= '0;
         r_last_slot   <= '0;
         r_fault_addr  <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_s_valid     <= w_s_valid_nxt;
         r_s_wstrb     <= w_s_wstrb_nxt;
         r_s_addr      <= w_s_addr_nxt;
         r_s_wdata     <= w_s_wdata_nxt;
         r_idx         <= w_idx_nxt;
         r_wd          <= w_wd_nxt;
         r_m_rdata     <= w_m_rdata_nxt;
         r_irq         <= w_irq_nxt;
         r_fault_count <= w_fault_count_nxt;
         r_last_slot   <= w_last_slot_nxt;
         r_fault_addr  <= w_fault_addr_nxt;
      end
   end

   assign m_ready     = (r_state == ST_RESP);
   assign m_rdata     = r_m_rdata;
   assign s_valid     = r_s_valid;
   assign s_wstrb     = r_s_wstrb;
   assign s_addr      = r_s_addr;
   assign s_wdata     = r_s_wdata;
   assign timeout_irq = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_iomem_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_iomem_scheduler: randomized bench for iomem_scheduler.     Rev 1.0  |
// +------------------------------------------------------------------------+
module tb_iomem_scheduler;

   localparam int         NS   = 5;
   localparam int         BASE = 3;
   localparam logic [4:0] PRES = 5'b01111;
   localparam int         TO   = 8;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          m_valid = 1'b0;
   logic          m_ready;
   logic [3:0]    m_wstrb = 4'h0;
   logic [31:0]   m_addr = '0;
   logic [31:0]   m_wdata = '0;
   logic [31:0]   m_rdata;
   logic [4:0]    s_valid;
   logic [3:0]    s_wstrb;
   logic [31:0]   s_addr;
   logic [31:0]   s_wdata;
   logic [4:0]    s_ready = '0;
   logic [159:0]  s_rdata = '0;
   logic          timeout_irq;

   int checks = 0;
   int errors = 0;

   iomem_scheduler #(
      .NSLOT(NS), .BASE_ID(8'h03), .PRESENT(PRES), .STATUS_ID(8'h08),
      .TIMEOUT(TO), .TIMEOUT_DATA(32'hDEAD_BEEF)
   ) dut (
      .clk(clk), .resetn(resetn),
      .m_valid(m_valid), .m_ready(m_ready), .m_wstrb(m_wstrb),
      .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
      .s_valid(s_valid), .s_wstrb(s_wstrb), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_ready(s_ready), .s_rdata(s_rdata), .timeout_irq(timeout_irq)
   );

   always #5 clk = ~clk;

   // Slot responder: selected slot answers after rsp_delay waiting cycles; others chatter.
   int rsp_delay = 1000;
   int rsp_cnt   = 0;
   always @(negedge clk) begin
      if (s_valid != '0) rsp_cnt = rsp_cnt + 1;
      else               rsp_cnt = 0;
      s_ready = 5'($urandom) & ~s_valid;
      if ((s_valid != '0) && (rsp_cnt == rsp_delay + 1)) s_ready = s_ready | s_valid;
   end

   // Reference model state and expectations.
   logic [15:0] m_fc = '0;
   logic [2:0]  m_ls = '0;
   logic [31:0] m_fa = '0;
   int          exp_lat, exp_irq, exp_svc;
   logic [31:0] exp_rd;
   logic [4:0]  exp_oh;

   int          obs_lat, obs_irq, obs_svc;
   logic [31:0] obs_rd;
   logic [4:0]  obs_oh;
   logic        obs_stable, obs_ready_after;

   function automatic void model_reset();
      m_fc = '0; m_ls = '0; m_fa = '0;
   endfunction

   function automatic void model_txn(input logic [31:0] a, input logic [3:0] ws, input int dly);
      int idx;
      idx = int'(a[31:24]) - BASE;
      exp_irq = 0; exp_svc = 0; exp_oh = '0; exp_lat = 1; exp_rd = '0;
      if (idx >= 0 && idx < NS && PRES[idx[2:0]]) begin
         exp_oh[idx[2:0]] = 1'b1;
         if (dly + 1 <= TO) begin
            exp_lat = dly + 2;
            exp_svc = dly + 1;
            exp_rd  = 32'(s_rdata >> (idx * 32));
         end else begin
            exp_lat = TO + 1;
            exp_svc = TO;
            exp_rd  = 32'hDEAD_BEEF;
            exp_irq = 1;
            if (m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
            m_ls = 3'(idx);
            m_fa = a;
         end
      end else if (a[31:24] == 8'h08) begin
         if (a[23:0] == 24'h0)      exp_rd = {m_fc, 13'b0, m_ls};
         else if (a[23:0] == 24'h4) exp_rd = m_fa;
         if (a[23:0] == 24'h0 && ws != 4'h0) begin m_fc = '0; m_ls = '0; end
      end
   endfunction

   task automatic run_txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                          input int dly);
      int cyc;
      rsp_delay = dly;
      @(negedge clk);
      m_valid = 1'b1; m_addr = a; m_wdata = wd; m_wstrb = ws;
      obs_irq = 0; obs_svc = 0; obs_oh = '0; obs_stable = 1'b1; cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (s_valid != '0) begin
            obs_svc++;
            obs_oh = obs_oh | s_valid;
            if (s_addr !== a || s_wdata !== wd || s_wstrb !== ws) obs_stable = 1'b0;
         end
         if (timeout_irq === 1'b1) obs_irq++;
      end while (m_ready !== 1'b1 && cyc < 200);
      obs_lat = (m_ready === 1'b1) ? cyc : -1;
      obs_rd  = m_rdata;
      m_valid = 1'b0;
      @(negedge clk);
      obs_ready_after = m_ready;
      if (timeout_irq === 1'b1) obs_irq++;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({m_ready, timeout_irq, s_valid, s_wstrb, s_addr, s_wdata, m_rdata} !== '0) begin
         errors++; $display("FAIL reset_outputs got %h want 0",
                            {m_ready, timeout_irq, s_valid, s_wstrb, s_addr, s_wdata, m_rdata});
      end
      resetn = 1'b1;
      model_reset();
      run_txn(32'h0800_0000, 32'h0, 4'h0, 0);
      checks++;
      if (obs_rd !== 32'h0) begin errors++; $display("FAIL reset_status got %h want 0", obs_rd); end
   endtask

   task automatic test_gpio_read();
      s_rdata = {$urandom, $urandom, $urandom, $urandom, 32'h0000_00A5};
      run_txn(32'h0300_0000, 32'h0, 4'h0, 0);
      model_txn(32'h0300_0000, 4'h0, 0);
      checks++;
      if (obs_lat !== 2) begin errors++; $display("FAIL gpio_latency got %0d want 2", obs_lat); end
      checks++;
      if (obs_rd !== 32'h0000_00A5) begin errors++; $display("FAIL gpio_rdata got %h want 000000a5", obs_rd); end
      checks++;
      if (obs_oh !== 5'b00001 || obs_svc !== 1) begin
         errors++; $display("FAIL gpio_svalid got %b/%0d want 00001/1", obs_oh, obs_svc);
      end
      checks++;
      if (obs_ready_after !== 1'b0) begin errors++; $display("FAIL gpio_ready_pulse got %b want 0", obs_ready_after); end
   endtask

   task automatic test_video_write();
      s_rdata = {$urandom, $urandom, $urandom, $urandom, $urandom};
      run_txn(32'h0500_0010, 32'h1234_5678, 4'hF, 3);
      model_txn(32'h0500_0010, 4'hF, 3);
      checks++;
      if (obs_svc !== 4 || obs_oh !== 5'b00100 || obs_stable !== 1'b1) begin
         errors++; $display("FAIL video_access got %0d/%b/%b want 4/00100/1", obs_svc, obs_oh, obs_stable);
      end
      checks++;
      if (obs_lat !== 5 || obs_ready_after !== 1'b0) begin
         errors++; $display("FAIL video_latency got %0d/%b want 5/0", obs_lat, obs_ready_after);
      end
      checks++;
      if (obs_rd !== exp_rd) begin errors++; $display("FAIL video_rdata got %h want %h", obs_rd, exp_rd); end
   endtask

   task automatic test_timeout_status();
      s_rdata = {$urandom, $urandom, $urandom, $urandom, $urandom};
      run_txn(32'h0600_0000, 32'h0, 4'h0, 1000);
      model_txn(32'h0600_0000, 4'h0, 1000);
      checks++;
      if (obs_svc !== TO || obs_lat !== TO + 1) begin
         errors++; $display("FAIL timeout_timing got %0d/%0d want %0d/%0d", obs_svc, obs_lat, TO, TO + 1);
      end
      checks++;
      if (obs_irq !== 1 || obs_rd !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL timeout_result got %0d/%h want 1/deadbeef", obs_irq, obs_rd);
      end
      run_txn(32'h0800_0000, 32'h0, 4'h0, 0);
      model_txn(32'h0800_0000, 4'h0, 0);
      checks++;
      if (obs_rd !== 32'h0001_0003 || obs_lat !== 1) begin
         errors++; $display("FAIL status0 got %h/%0d want 00010003/1", obs_rd, obs_lat);
      end
      run_txn(32'h0800_0004, 32'h0, 4'h0, 0);
      model_txn(32'h0800_0004, 4'h0, 0);
      checks++;
      if (obs_rd !== 32'h0600_0000) begin errors++; $display("FAIL status4 got %h want 06000000", obs_rd); end
   endtask

   task automatic test_unmapped();
      run_txn(32'h0900_0000, 32'hFFFF_FFFF, 4'hF, 0);
      checks++;
      if (obs_lat !== 1 || obs_rd !== 32'h0 || obs_svc !== 0) begin
         errors++; $display("FAIL unmapped09 got %0d/%h/%0d want 1/0/0", obs_lat, obs_rd, obs_svc);
      end
      run_txn(32'h0700_0000, 32'h0, 4'h0, 0);
      checks++;
      if (obs_lat !== 1 || obs_rd !== 32'h0 || obs_svc !== 0) begin
         errors++; $display("FAIL absent_slot got %0d/%h/%0d want 1/0/0", obs_lat, obs_rd, obs_svc);
      end
   endtask

   task automatic test_ready_on_expiry();
      s_rdata = {$urandom, $urandom, $urandom, $urandom, $urandom};
      run_txn(32'h0400_0020, 32'h0, 4'h0, TO - 1);
      model_txn(32'h0400_0020, 4'h0, TO - 1);
      checks++;
      if (obs_irq !== 0 || obs_rd !== exp_rd || obs_lat !== TO + 1) begin
         errors++; $display("FAIL expiry_tie got %0d/%h/%0d want 0/%h/%0d", obs_irq, obs_rd, obs_lat, exp_rd, TO + 1);
      end
      run_txn(32'h0800_0000, 32'h0, 4'h0, 0);
      model_txn(32'h0800_0000, 4'h0, 0);
      checks++;
      if (obs_rd !== 32'h0001_0003) begin errors++; $display("FAIL expiry_count got %h want 00010003", obs_rd); end
      run_txn(32'h0800_0000, 32'h0, 4'h1, 0);
      model_txn(32'h0800_0000, 4'h1, 0);
      run_txn(32'h0800_0000, 32'h0, 4'h0, 0);
      model_txn(32'h0800_0000, 4'h0, 0);
      checks++;
      if (obs_rd !== 32'h0) begin errors++; $display("FAIL status_clear got %h want 0", obs_rd); end
      run_txn(32'h0800_0004, 32'h0, 4'h0, 0);
      model_txn(32'h0800_0004, 4'h0, 0);
      checks++;
      if (obs_rd !== 32'h0600_0000) begin errors++; $display("FAIL fault_addr_kept got %h want 06000000", obs_rd); end
   endtask

   task automatic test_random();
      logic [31:0] a;
      logic [3:0]  ws;
      logic [7:0]  page;
      int          dly;
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 5))
            0, 1:    page = 8'h03 + 8'($urandom_range(0, 3));
            2:       page = 8'h08;
            3:       page = 8'h07;
            default: page = 8'($urandom);
         endcase
         if (page == 8'h08) a = {page, 24'(4 * $urandom_range(0, 2))};
         else               a = {page, 24'($urandom) & 24'hFF_FFFC};
         ws  = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
         dly = $urandom_range(0, 11);
         s_rdata = {$urandom, $urandom, $urandom, $urandom, $urandom};
         run_txn(a, $urandom, ws, dly);
         model_txn(a, ws, dly);
         checks++;
         if (obs_lat !== exp_lat || obs_rd !== exp_rd) begin
            errors++; $display("FAIL rnd_resp addr %h got %0d/%h want %0d/%h", a, obs_lat, obs_rd, exp_lat, exp_rd);
         end
         checks++;
         if (obs_irq !== exp_irq || obs_svc !== exp_svc || obs_oh !== exp_oh || obs_stable !== 1'b1) begin
            errors++; $display("FAIL rnd_slot addr %h got %0d/%0d/%b/%b want %0d/%0d/%b/1",
                               a, obs_irq, obs_svc, obs_oh, obs_stable, exp_irq, exp_svc, exp_oh);
         end
      end
   endtask

   task automatic test_async_reset();
      int seen;
      rsp_delay = 1000;
      @(negedge clk);
      m_valid = 1'b1; m_addr = 32'h0400_0000; m_wdata = 32'h0; m_wstrb = 4'h0;
      repeat (3) @(negedge clk);
      checks++;
      if (s_valid !== 5'b00010) begin errors++; $display("FAIL areset_pre got %b want 00010", s_valid); end
      #2 resetn = 1'b0;
      m_valid = 1'b0;
      #1;
      checks++;
      if ({m_ready, timeout_irq, s_valid, s_wstrb, s_addr, s_wdata, m_rdata} !== '0) begin
         errors++; $display("FAIL areset_async got %h want 0",
                            {m_ready, timeout_irq, s_valid, s_wstrb, s_addr, s_wdata, m_rdata});
      end
      @(negedge clk);
      resetn = 1'b1;
      model_reset();
      seen = 0;
      repeat (5) begin
         @(negedge clk);
         if (m_ready === 1'b1) seen++;
      end
      checks++;
      if (seen !== 0) begin errors++; $display("FAIL areset_no_resp got %0d want 0", seen); end
      s_rdata = {$urandom, $urandom, $urandom, $urandom, $urandom};
      run_txn(32'h0400_0008, 32'h0, 4'h0, 1);
      model_txn(32'h0400_0008, 4'h0, 1);
      checks++;
      if (obs_lat !== exp_lat || obs_rd !== exp_rd) begin
         errors++; $display("FAIL areset_next got %0d/%h want %0d/%h", obs_lat, obs_rd, exp_lat, exp_rd);
      end
   endtask

   initial begin
      test_reset();
      test_gpio_read();
      test_video_write();
      test_timeout_status();
      test_unmapped();
      test_ready_on_expiry();
      test_random();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/iomem_scheduler.md
Name: iomem_scheduler

Overview:
Sequencer and arbiter for the SoC peripheral bus, sitting between the picosoc iomem master port and the peripheral slots. It replaces ad-hoc combinational ready/rdata muxing with a registered one-outstanding-transaction engine. The engine does address-page decode, one-hot slot selection and a per-access watchdog timeout. It also provides a small fault/status page readable by firmware.

Parameters:
NSLOT, 5, number of peripheral slots; slot i owns address page BASE_ID+i
BASE_ID, 8'h03, addr[31:24] page of slot 0 (gpio=03, audio=04, video=05, sdcard=06, i2c=07)
PRESENT, 5'b11111, bit i=1 means slot i is populated; unpopulated slots are treated as unmapped
STATUS_ID, 8'h08, addr[31:24] page of the scheduler status registers
TIMEOUT, 255, max cycles in ACCESS before forced completion; legal range 1..65535
TIMEOUT_DATA, 32'hDEAD_BEEF, rdata returned on a timed-out access

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
m_valid  input  1  master request valid
m_ready  output  1  master response, one-cycle pulse
m_wstrb  input  4  byte write strobes; 0 = read
m_addr  input  32  byte address
m_wdata  input  32  write data
m_rdata  output  32  read data, valid while m_ready=1
s_valid  output  NSLOT  one-hot slot request
s_wstrb  output  4  registered copy of m_wstrb
s_addr  output  32  registered copy of m_addr
s_wdata  output  32  registered copy of m_wdata
s_ready  input  NSLOT  per-slot completion
s_rdata  input  32*NSLOT  per-slot read data; slot i in bits [32i+31:32i]
timeout_irq  output  1  one-cycle pulse on watchdog expiry

Behaviour:
- Reset (async, resetn=0): state=IDLE; outputs m_ready, m_rdata, s_valid, s_wstrb, s_addr, s_wdata and timeout_irq all 0; fault_count=0, last_slot=0, fault_addr=0, watchdog=0. s_valid falls immediately, not at the next edge. Reset asserted mid-transaction aborts it silently with no response.
- Decode: page=m_addr[31:24]; idx=page-BASE_ID. The access is mapped if 0<=idx<NSLOT and PRESENT[idx]=1.
- State machine has three states: IDLE, ACCESS, RESP.
- IDLE, m_valid=1, mapped:
  - latch addr/wdata/wstrb into s_*; s_valid[idx]=1; watchdog=0; go to ACCESS.
- IDLE, m_valid=1, page==STATUS_ID:
  - load m_rdata from the status mux; apply any write; go to RESP.
- IDLE, m_valid=1, other pages:
  - m_rdata=0; go to RESP (write ignored).
- ACCESS:
  - hold s_valid and s_* stable; watchdog increments by 1 per cycle.
  - If s_ready[idx]=1: m_rdata=s_rdata slice idx (captured for writes as well); s_valid=0; go to RESP.
  - Else if watchdog==TIMEOUT-1: s_valid=0; m_rdata=TIMEOUT_DATA; fault_count increments, saturating at 16'hFFFF; last_slot=idx; fault_addr=s_addr; timeout_irq=1 for one cycle; go to RESP.
  - If s_ready and expiry coincide, s_ready wins: normal completion, no fault.
  - s_ready on non-selected slots is ignored.
- RESP:
  - m_ready=1 for exactly one cycle with m_rdata stable; then go to IDLE.
  - m_rdata holds its value until the next capture.
- m_valid dropping during ACCESS is a protocol violation. The access still completes and RESP is still issued.
- Latency, counted from the edge sampling m_valid:
  - unmapped/status access: m_ready in cycle 1;
  - mapped access with s_ready in first ACCESS cycle: m_ready in cycle 2;
  - timeout: m_ready in cycle TIMEOUT+1.
- Status page registers:
  - offset 0x0 read: {fault_count[15:0], 13'b0, last_slot[2:0]};
  - offset 0x4 read: fault_addr;
  - other offsets read 0.
  - Write to offset 0x0 with wstrb!=0 clears fault_count and last_slot. fault_addr is not cleared.
  - A write that clears in the same cycle as a timeout increment cannot occur, since there is only one outstanding access.
- Only one transaction is in flight; there is no pipelining or back-to-back overlap. The minimum gap between responses is one IDLE cycle.

Test Plan:
- Read 0x0300_0000; gpio slot returns s_ready=1 on the first ACCESS cycle with rdata 0x0000_00A5 -> s_valid=5'b00001 for 1 cycle, m_ready pulses in cycle 2, m_rdata=0x0000_00A5.
- Write 0x0500_0010, wdata 0x1234_5678, wstrb 4'hF; video slot delays s_ready by 3 cycles -> s_addr/s_wdata/s_wstrb stable for 4 ACCESS cycles, s_valid=5'b00100, single m_ready pulse.
- With TIMEOUT=8, read 0x0600_0000 and sdcard never readies -> s_valid falls after 8 cycles, timeout_irq pulses once, m_rdata=0xDEAD_BEEF. A following read of 0x0800_0000 returns 0x0001_0003 and 0x0800_0004 returns 0x0600_0000.
- Read 0x0900_0000, and read 0x0700_0000 with PRESENT=5'b01111 -> m_ready in cycle 1, m_rdata=0, s_valid never asserted.
- s_ready asserted exactly on the watchdog expiry cycle -> normal data returned, no irq, fault_count unchanged. Write 0x0800_0000 wstrb=4'h1 -> fault_count reads 0.
- resetn pulled low for 1 cycle mid-ACCESS -> s_valid drops asynchronously, no m_ready, all outputs 0; the next access completes normally.
